// File: rtl/pipe_pkg.sv
// Shared types and defaults for the EX/MEM elastic pipeline register.
// Optional perf counters in the top are enabled by EX_MEM_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_REGWRITE = 3;

    // Occupancy is fully described by the two slot valid bits.
    function automatic state_t slot_state(input logic main_v, input logic skid_v);
        if (!main_v)
            return ST_EMPTY;
        else if (!skid_v)
            return ST_ONE;
        else
            return ST_FULL;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register; clear has priority over load.
module pipe_slot #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Clearing drops only the valid bit; the stale payload is harmless.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// Elastic EX/MEM register: main slot drives MEM, skid slot absorbs one beat of stall.
// Define EX_MEM_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module ex_mem_skid_reg #(
    parameter int unsigned CTRL_W   = pipe_pkg::CTRL_W,
    parameter int unsigned DATA_W   = pipe_pkg::DATA_W,
    parameter int unsigned NUM_DATA = 2,
    parameter int unsigned REG_W    = pipe_pkg::REG_W,
    parameter int unsigned NUM_REG  = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]   in_data,
    input  logic [NUM_REG*REG_W-1:0]     in_reg,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0]   out_data,
    output logic [NUM_REG*REG_W-1:0]     out_reg
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt
`endif
);

    import pipe_pkg::*;

    localparam int unsigned RW_ALL = NUM_REG * REG_W;
    localparam int unsigned DW_ALL = NUM_DATA * DATA_W;
    localparam int unsigned PW     = CTRL_W + DW_ALL + RW_ALL;

    logic          main_v, skid_v;
    logic [PW-1:0] in_pl, main_pl, skid_pl, main_d;
    logic          acc, take;
    logic          main_load, main_clr, skid_load, skid_clr;
    state_t        state;

    assign state    = slot_state(main_v, skid_v);
    assign in_ready = reset_n & (state != ST_FULL) & ~flush;
    assign acc      = in_valid & in_ready;
    assign take     = main_v & out_ready;
    assign in_pl    = {in_ctrl, in_data, in_reg};

    // Main refills from skid if occupied, else straight from EX; it empties
    // only when taken with nothing behind it. Flush wins over everything.
    assign main_d    = skid_v ? skid_pl : in_pl;
    assign main_load = ~flush & ((~main_v & acc) | (take & (skid_v | acc)));
    assign main_clr  = flush | (take & ~skid_v & ~acc);
    assign skid_load = ~flush & main_v & ~skid_v & acc & ~take;
    assign skid_clr  = flush | (take & skid_v);

    pipe_slot #(.W(PW)) u_main (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .load_i  (main_load),
        .clear_i (main_clr),
        .d_i     (main_d),
        .valid_o (main_v),
        .q_o     (main_pl)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .d_i     (in_pl),
        .valid_o (skid_v),
        .q_o     (skid_pl)
    );

    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_pl[PW-1 -: CTRL_W] : '0;
    assign out_data  = main_pl[RW_ALL +: DW_ALL];
    assign out_reg   = main_pl[RW_ALL-1:0];

`ifdef EX_MEM_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_v && !out_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!main_v && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: the reference is a 2-deep FIFO queue
// updated once per cycle from the handshakes, independent of slot structure.
module tb_ex_mem_skid_reg;

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned ND = 2;
    localparam int unsigned RW = 5;
    localparam int unsigned NR = 3;

    logic              clk = 1'b0;
    logic              reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0]     in_ctrl, out_ctrl;
    logic [ND*DW-1:0]  in_data, out_data;
    logic [NR*RW-1:0]  in_reg, out_reg;
`ifdef EX_MEM_PERF_EN
    logic [31:0]       stall_cnt, bubble_cnt;
    int unsigned       stall_m, bubble_m;
`endif

    typedef struct {
        logic [CW-1:0]    c;
        logic [ND*DW-1:0] d;
        logic [NR*RW-1:0] r;
    } beat_t;

    beat_t       q[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(
        .CTRL_W   (CW),
        .DATA_W   (DW),
        .NUM_DATA (ND),
        .REG_W    (RW),
        .NUM_REG  (NR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .in_reg     (in_reg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .out_reg    (out_reg)
`ifdef EX_MEM_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare DUT against the queue, then advance the queue with this cycle's handshakes.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
`ifdef EX_MEM_PERF_EN
            stall_m  = 0;
            bubble_m = 0;
`endif
        end else begin
            bit m_ready;
            bit m_acc;
            m_ready = (q.size() < 2) && !flush;
            m_acc   = in_valid && m_ready;
            check("in_ready", 64'(in_ready), 64'(m_ready));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
                check("out_data", out_data, q[0].d);
                check("out_reg", 64'(out_reg), 64'(q[0].r));
            end else begin
                check("out_ctrl_mask", 64'(out_ctrl), 64'd0);
            end
`ifdef EX_MEM_PERF_EN
            check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            check("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
            if (q.size() > 0 && !out_ready) stall_m++;
            if (q.size() == 0) bubble_m++;
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (m_acc) q.push_back('{c: in_ctrl, d: in_data, r: in_reg});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [ND*DW-1:0] d,
                         input logic [NR*RW-1:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_reg   = r;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        reset_n = 1'b1;
        tick();

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b1001, {32'hDEAD_BEEF, 32'h0000_0010 + 32'(i)},
                  {5'd3, 5'd2, 5'(1 + i)});
            tick();
        end
        drive(1'b0, '0, '0, '0);
        repeat (2) tick();

        // Back-pressure: A then B stall, then release in order
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 64'h1, 15'h21);
        tick();
        drive(1'b1, 4'b0010, 64'h2, 15'h42);
        tick();
        drive(1'b0, '0, '0, '0);
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush while full with a beat offered
        out_ready = 1'b0;
        drive(1'b1, 4'b0100, 64'h3, 15'h3);
        tick();
        drive(1'b1, 4'b1000, 64'h4, 15'h4);
        tick();
        drive(1'b1, 4'b1111, 64'hBAD, 15'h7FFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (3) tick();

        // 100 back-to-back beats with simultaneous accept and take
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 4'($urandom), {$urandom, $urandom}, 15'($urandom));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        repeat (2) tick();

        // Random mix of stalls, bubbles and occasional flushes
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 4'($urandom), {$urandom, $urandom}, 15'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Stall for 5 cycles, then 3 idle cycles
        out_ready = 1'b0;
        drive(1'b1, 4'b1010, 64'h55, 15'h5);
        tick();
        drive(1'b0, '0, '0, '0);
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (4) tick();

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 4'b0011, 64'hA, 15'hA);
        tick();
        drive(1'b1, 4'b0110, 64'hB, 15'hB);
        tick();
        drive(1'b0, '0, '0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("async_rst_out_data", out_data, 64'd0);
        check("async_rst_out_reg", 64'(out_reg), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Drain: a short stream must fully come out
        out_ready = 1'b1;
        drive(1'b1, 4'b0101, 64'hC0FFEE, 15'h1F);
        tick();
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 10 && q.size() != 0; k++) tick();
        tick();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
